// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, constants and GF(2^8)/byte-layout helpers.
// State bytes are column-major with s0,0 in bits [127:120].
package aes_pkg;
   localparam int BYTE = 8;
   localparam int WORD = 32;
   localparam int SENTENCE = 128;
   localparam logic [3:0] NR = 4'd10;

   typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} state_e;

   // Index 0 and 11..15 are never used; padding keeps a 4-bit index in range.
   localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic logic [7:0] mul11(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
   endfunction

   function automatic logic [7:0] mul13(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
   endfunction

   function automatic logic [7:0] mul14(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq = a;
      logic [7:0] r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq = gf_mul(sq, sq);
         r = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] t;
      t = {x, x} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
   endfunction

   function automatic logic [WORD-1:0] rot_word(input logic [WORD-1:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [WORD-1:0] sub_word(input logic [WORD-1:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [SENTENCE-1:0] inv_shift_rows(input logic [SENTENCE-1:0] s);
      logic [SENTENCE-1:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [SENTENCE-1:0] inv_sub_bytes(input logic [SENTENCE-1:0] s);
      logic [SENTENCE-1:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [SENTENCE-1:0] inv_mix_columns(input logic [SENTENCE-1:0] s);
      logic [SENTENCE-1:0] o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127-32*c -: 32];
         o[127-32*c -: 32] = {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                              mul9(a0) ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                              mul13(a0) ^ mul9(a1) ^ mul14(a2) ^ mul11(a3),
                              mul11(a0) ^ mul13(a1) ^ mul9(a2) ^ mul14(a3)};
      end
      return o;
   endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, forward (dir_i=0) or inverse (dir_i=1).
module aes_key_step
   import aes_pkg::*;
(
   input  logic [SENTENCE-1:0] rk_i,
   input  logic [BYTE-1:0]     rc_i,
   input  logic                dir_i,
   output logic [SENTENCE-1:0] rk_o
);
   logic [WORD-1:0] w0, w1, w2, w3, t, f0, f1, f2;

   assign {w0, w1, w2, w3} = rk_i;
   // The inverse step needs SubWord of the recovered w3, which is w3^w2.
   assign t = sub_word(rot_word(dir_i ? w3 ^ w2 : w3)) ^ {rc_i, 24'h0};
   assign f0 = w0 ^ t;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign rk_o = dir_i ? {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2} : {f0, f1, f2, w3 ^ f2};
endmodule

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryption, one round per clock with Start/Done handshake.
// The key is expanded forward to round 10, then walked backwards in the same register.
module aes_inv_cipher
   import aes_pkg::*;
(
   input  logic                CLK,
   input  logic                Reset,
   input  logic                Start,
   input  logic [SENTENCE-1:0] Cipher_Text,
   input  logic [SENTENCE-1:0] Key,
   output logic [SENTENCE-1:0] Plain_Text,
   output logic                Done,
   output logic                Busy
);
   state_e state_q, state_d;
   logic [3:0] rnd_q, rnd_d;
   logic [SENTENCE-1:0] ct_q, ct_d, rk_q, rk_d, st_q, st_d, pt_q, pt_d, step_rk, isb;
   logic done_q, done_d, busy_q, busy_d;

   assign isb = inv_sub_bytes(inv_shift_rows(st_q));

   aes_key_step u_key_step (
      .rk_i  (rk_q),
      .rc_i  (RCON[state_q == KEYEXP ? rnd_q + 4'd1 : rnd_q]),
      .dir_i (state_q != KEYEXP),
      .rk_o  (step_rk)
   );

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
         rnd_q <= '0;
         ct_q <= '0;
         rk_q <= '0;
         st_q <= '0;
         pt_q <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q <= rnd_d;
         ct_q <= ct_d;
         rk_q <= rk_d;
         st_q <= st_d;
         pt_q <= pt_d;
         done_q <= done_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rnd_d = rnd_q;
      ct_d = ct_q;
      rk_d = rk_q;
      st_d = st_q;
      pt_d = pt_q;
      done_d = 1'b0;
      busy_d = busy_q;
      case (state_q)
         IDLE: if (Start) begin
            ct_d = Cipher_Text;
            rk_d = Key;
            rnd_d = '0;
            busy_d = 1'b1;
            state_d = KEYEXP;
         end
         KEYEXP: begin
            rk_d = step_rk;
            rnd_d = rnd_q + 4'd1;
            if (rnd_q + 4'd1 == NR) state_d = INIT;
         end
         INIT: begin
            st_d = ct_q ^ rk_q;
            rk_d = step_rk;
            rnd_d = NR - 4'd1;
            state_d = ROUND;
         end
         ROUND: begin
            st_d = inv_mix_columns(isb ^ rk_q);
            rk_d = step_rk;
            rnd_d = rnd_q - 4'd1;
            if (rnd_q == 4'd1) state_d = FINAL;
         end
         FINAL: begin
            pt_d = isb ^ rk_q;
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign Plain_Text = pt_q;
   assign Done = done_q;
   assign Busy = busy_q;
endmodule
